// File: rtl/seq_alu_mc_if.sv
// ============================================================================
// Module   : seq_alu_mc_if
// Purpose  : Request/response bundle between the register file, seq_alu_mc
//            and writeback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_alu_mc_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] inA;
   logic [WIDTH-1:0] inB;
   logic             inC;
   logic [2:0]       opc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] outW;
   logic             zer;
   logic             neg;
   logic             cout;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, inA, inB, inC, opc, out_ready,
      input  in_ready, out_valid, outW, zer, neg, cout, ovf, busy
   );

   modport slave (
      input  in_valid, inA, inB, inC, opc, out_ready,
      output in_ready, out_valid, outW, zer, neg, cout, ovf, busy
   );
endinterface

`default_nettype wire

// File: rtl/seq_alu_mc.sv
// ============================================================================
// Module   : seq_alu_mc
// Purpose  : Registered WIDTH-bit ALU with flags and a multi-cycle shift-add
//            multiply, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_mc #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   seq_alu_mc_if.slave  bus
);

   localparam logic [0:0]       c_IDLE = 1'b0;
   localparam logic [0:0]       c_MUL  = 1'b1;
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
   localparam int               c_HALF = WIDTH / 2;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] outw_q, outw_d;
   logic             zer_q, zer_d;
   logic             neg_q, neg_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_is_mul;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_add_a;
   logic [WIDTH-1:0] w_add_b;
   logic             w_add_c;
   logic             w_is_add;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_alu;
   logic             w_alu_cout;
   logic             w_alu_ovf;
   logic [WIDTH-1:0] w_acc_step;
   logic             w_load;
   logic [WIDTH-1:0] w_load_val;
   logic             w_load_cout;
   logic             w_load_ovf;

   assign w_in_ready = (state_q == c_IDLE) && (!out_valid_q || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_is_mul   = (bus.opc == 3'b111);
   assign w_mul_done = (state_q == c_MUL) && (cnt_q == c_LAST);
   assign w_acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   // Single-cycle datapath; every arithmetic op funnels through one adder.
   always_comb begin
      w_add_a  = bus.inA;
      w_add_b  = '0;
      w_add_c  = 1'b0;
      w_is_add = 1'b0;
      w_alu    = '0;
      case (bus.opc)
         3'b000: begin
            w_add_a  = ~bus.inA;
            w_add_b  = WIDTH'(1);
            w_is_add = 1'b1;
         end
         3'b001: begin
            w_add_b  = WIDTH'(1);
            w_is_add = 1'b1;
         end
         3'b010: begin
            w_add_b  = bus.inB;
            w_add_c  = bus.inC;
            w_is_add = 1'b1;
         end
         3'b011: begin
            w_add_b  = {bus.inB[WIDTH-1], bus.inB[WIDTH-1:1]};
            w_is_add = 1'b1;
         end
         3'b100:  w_alu = bus.inA & bus.inB;
         3'b101:  w_alu = bus.inA | bus.inB;
         3'b110:  w_alu = {bus.inA[c_HALF-1:0], bus.inB[c_HALF-1:0]};
         default: w_alu = '0;
      endcase
      w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_c};
      if (w_is_add) begin
         w_alu = w_sum[WIDTH-1:0];
      end
      w_alu_cout = w_is_add && w_sum[WIDTH];
      w_alu_ovf  = w_is_add && (w_add_a[WIDTH-1] == w_add_b[WIDTH-1])
                            && (w_sum[WIDTH-1] != w_add_a[WIDTH-1]);
   end

   // Accept and multiply completion are mutually exclusive (IDLE vs MUL).
   always_comb begin
      w_load      = 1'b0;
      w_load_val  = w_alu;
      w_load_cout = w_alu_cout;
      w_load_ovf  = w_alu_ovf;
      if (w_accept && !w_is_mul) begin
         w_load = 1'b1;
      end else if (w_mul_done) begin
         w_load      = 1'b1;
         w_load_val  = w_acc_step;
         w_load_cout = 1'b0;
         w_load_ovf  = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      outw_d      = outw_q;
      zer_d       = zer_q;
      neg_d       = neg_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;

      if (state_q == c_IDLE) begin
         if (w_accept && w_is_mul) begin
            mcand_d  = bus.inA;
            mplier_d = bus.inB;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = c_MUL;
         end
      end else begin
         acc_d    = w_acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (w_mul_done) begin
            busy_d  = 1'b0;
            state_d = c_IDLE;
         end
      end

      if (w_load) begin
         outw_d      = w_load_val;
         zer_d       = (w_load_val == '0);
         neg_d       = w_load_val[WIDTH-1];
         cout_d      = w_load_cout;
         ovf_d       = w_load_ovf;
         out_valid_d = 1'b1;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= c_IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         outw_q      <= '0;
         zer_q       <= 1'b0;
         neg_q       <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         outw_q      <= outw_d;
         zer_q       <= zer_d;
         neg_q       <= neg_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.outW      = outw_q;
   assign bus.zer       = zer_q;
   assign bus.neg       = neg_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu_mc.sv
// ============================================================================
// Module   : tb_seq_alu_mc
// Purpose  : Directed self-checking bench for seq_alu_mc at WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu_mc;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fails  = 0;

   seq_alu_mc_if #(.WIDTH(16)) bus ();

   seq_alu_mc #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic c);
      bus.in_valid = v;
      bus.opc      = op;
      bus.inA      = a;
      bus.inB      = b;
      bus.inC      = c;
   endtask

   task automatic test_reset();
      step();
      step();
      n_checks++;
      if ({bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf, bus.busy} !== 22'h0) begin
         n_fails++;
         $display("FAIL reset_state: got v=%b w=%h z=%b n=%b c=%b o=%b busy=%b, want all 0",
                  bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf, bus.busy);
      end
      rst_n = 1'b1;
      step();
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_adder_flags();
      drive(1'b1, 3'b010, 16'h7FFF, 16'h0001, 1'b0);
      step();
      n_checks++;
      if ({bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf} !== {1'b1, 16'h8000, 4'b0101}) begin
         n_fails++;
         $display("FAIL add_ovf: got v=%b w=%h zncv=%b%b%b%b want v=1 w=8000 zncv=0101",
                  bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf);
      end
      drive(1'b1, 3'b000, 16'h0000, 16'h1234, 1'b1);
      step();
      n_checks++;
      if ({bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf} !== {1'b1, 16'h0000, 4'b1010}) begin
         n_fails++;
         $display("FAIL neg_zero: got v=%b w=%h zncv=%b%b%b%b want v=1 w=0000 zncv=1010",
                  bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf);
      end
      drive(1'b1, 3'b000, 16'h8000, 16'h0000, 1'b0);
      step();
      n_checks++;
      if ({bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf} !== {1'b1, 16'h8000, 4'b0101}) begin
         n_fails++;
         $display("FAIL neg_min: got v=%b w=%h zncv=%b%b%b%b want v=1 w=8000 zncv=0101",
                  bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf);
      end
      drive(1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0);
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL drain: out_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_shift_concat();
      drive(1'b1, 3'b011, 16'h0010, 16'hFFF0, 1'b1);
      step();
      n_checks++;
      if ({bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf} !== {1'b1, 16'h0008, 4'b0010}) begin
         n_fails++;
         $display("FAIL shift_add: got v=%b w=%h zncv=%b%b%b%b want v=1 w=0008 zncv=0010",
                  bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf);
      end
      drive(1'b1, 3'b110, 16'h12AB, 16'h34CD, 1'b0);
      step();
      n_checks++;
      if ({bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf} !== {1'b1, 16'hABCD, 4'b0100}) begin
         n_fails++;
         $display("FAIL concat: got v=%b w=%h zncv=%b%b%b%b want v=1 w=ABCD zncv=0100",
                  bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf);
      end
      drive(1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0);
      step();
   endtask

   task automatic test_multiply();
      drive(1'b1, 3'b111, 16'hFFFD, 16'h0007, 1'b0);
      step();
      drive(1'b1, 3'b101, 16'h1111, 16'h2222, 1'b0);
      for (int k = 0; k < 16; k++) begin
         n_checks++;
         if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b100) begin
            n_fails++;
            $display("FAIL mul_busy[%0d]: got busy/in_ready/out_valid=%b%b%b want 100",
                     k, bus.busy, bus.in_ready, bus.out_valid);
         end
         if (k == 15) begin
            drive(1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0);
         end
         step();
      end
      n_checks++;
      if ({bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf, bus.busy} !== {1'b1, 16'hFFEB, 5'b01000}) begin
         n_fails++;
         $display("FAIL mul_result: got v=%b w=%h zncv=%b%b%b%b busy=%b want v=1 w=FFEB zncv=0100 busy=0",
                  bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf, bus.busy);
      end
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL mul_single_result: out_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      drive(1'b1, 3'b100, 16'h00FF, 16'h0F0F, 1'b0);
      step();
      drive(1'b1, 3'b101, 16'h00F0, 16'h0F00, 1'b0);
      for (int k = 0; k < 10; k++) begin
         n_checks++;
         if ({bus.in_ready, bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf} !== {2'b01, 16'h000F, 4'b0000}) begin
            n_fails++;
            $display("FAIL stall[%0d]: got rdy=%b v=%b w=%h zncv=%b%b%b%b want rdy=0 v=1 w=000F zncv=0000",
                     k, bus.in_ready, bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf);
         end
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL release_ready: got %b want 1", bus.in_ready);
      end
      step();
      n_checks++;
      if ({bus.out_valid, bus.outW} !== {1'b1, 16'h0FF0}) begin
         n_fails++;
         $display("FAIL release_result: got v=%b w=%h want v=1 w=0FF0", bus.out_valid, bus.outW);
      end
      drive(1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0);
      step();
   endtask

   task automatic test_back_to_back();
      logic [15:0] a;
      for (int i = 0; i < 8; i++) begin
         a = 16'(i);
         drive(1'b1, 3'b001, a, 16'h0000, 1'b0);
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.in_ready);
         end
         step();
         n_checks++;
         if ({bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf} !== {1'b1, a + 16'd1, 4'b0000}) begin
            n_fails++;
            $display("FAIL b2b_result[%0d]: got v=%b w=%h zncv=%b%b%b%b want v=1 w=%h zncv=0000",
                     i, bus.out_valid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf, a + 16'd1);
         end
      end
      drive(1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0);
      step();
   endtask

   task automatic test_reset_mid_mul();
      drive(1'b1, 3'b111, 16'h0003, 16'h0005, 1'b0);
      step();
      drive(1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0);
      step();
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.out_valid, bus.outW, bus.busy} !== 18'h0) begin
         n_fails++;
         $display("FAIL async_reset: got v=%b w=%h busy=%b want 0 0000 0",
                  bus.out_valid, bus.outW, bus.busy);
      end
      step();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL post_reset_ready: got %b want 1", bus.in_ready);
      end
      for (int k = 0; k < 20; k++) begin
         step();
         n_checks++;
         if ({bus.out_valid, bus.busy, bus.outW} !== 18'h0) begin
            n_fails++;
            $display("FAIL stale_result[%0d]: got v=%b busy=%b w=%h want 0 0 0000",
                     k, bus.out_valid, bus.busy, bus.outW);
         end
      end
   endtask

   initial begin
      bus.out_ready = 1'b1;
      drive(1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0);
      test_reset();
      test_adder_flags();
      test_shift_concat();
      test_multiply();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_mul();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seq_alu_mc.md
Name: seq_alu_mc

Overview:
- Parametrised, registered successor of the team's 16-bit combinational ALU.
- Keeps the same opcode map and zer/neg flags, widened to WIDTH bits, and adds signed overflow and carry-out flags.
- Opcode 111 becomes a multi-cycle shift-add multiply; all other opcodes are single-cycle.
- Sits between the datapath register file and writeback. Uses a valid/ready handshake on both sides and holds one result in its output register.

Parameters:
- WIDTH, 16, operand/result width; must be even and at least 4.
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- inA  in  WIDTH  signed operand A
- inB  in  WIDTH  signed operand B
- inC  in  1  carry-in, used by opc 010 only
- opc  in  3  operation select
- out_valid  out  1  outW and flags hold a valid result
- out_ready  in  1  consumer takes the result
- outW  out  WIDTH  registered result
- zer  out  1  outW == 0
- neg  out  1  outW[WIDTH-1]
- cout  out  1  carry out of the adder
- ovf  out  1  signed overflow
- busy  out  1  multiply in progress

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid, outW, zer, neg, cout, ovf and busy all 0.
  - A multiply in progress is abandoned and no result is produced.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept occurs on a rising edge with in_valid && in_ready; operands and opc are captured at that edge.
  - The result register holds outW and the flags stable while out_valid && !out_ready.
  - out_valid clears on an out_ready edge unless a new single-cycle result loads on the same edge (back-to-back allowed, full throughput).
- Opcodes. The adder computes A' + B' + c', WIDTH+1 bits wide.
  - 000: A'=~inA, B'=1, c'=0 (negate). cout=1 iff inA==0. ovf=1 iff inA==100..0.
  - 001: A'=inA, B'=1, c'=0 (increment). ovf=1 iff inA==011..1.
  - 010: A'=inA, B'=inB, c'=inC.
  - 011: A'=inA, B'=inB>>>1 (arithmetic shift), c'=0.
  - For all adder ops: cout is adder bit WIDTH; ovf = (A'[msb]==B'[msb]) && (res[msb]!=A'[msb]).
  - 100: inA & inB. 101: inA | inB.
  - 110: {inA[WIDTH/2-1:0], inB[WIDTH/2-1:0]}.
  - 111: low WIDTH bits of inA*inB. Two's-complement correct, so no signed correction is needed.
  - Non-adder ops: cout=0, ovf=0.
  - zer and neg are always derived from the value written to outW and registered with it.
- Latency:
  - Single-cycle ops: result and out_valid are registered at the accept edge and visible the next cycle.
  - Multiply: out_valid rises exactly WIDTH cycles after the accept edge.
- Multiply FSM: IDLE -> MUL -> IDLE.
  - Accept of opc 111: mcand=inA, mplier=inB, acc=0, cnt=0, busy=1, state=MUL.
  - Each MUL cycle: if mplier[0], acc+=mcand (mod 2^WIDTH); mcand<<=1; mplier>>=1; cnt++.
  - On the edge where cnt reaches WIDTH-1: write acc' to outW and set the flags, out_valid=1, busy=0, state=IDLE.
  - in_ready=0 throughout MUL.
  - Entry into MUL requires the output register to be empty or draining, so the result write never collides with an unconsumed result.
- in_valid while in_ready=0 is ignored. The requester must hold its request; the block does not queue it.

Test Plan:
- Reset mid-multiply, WIDTH=16: accept opc 111, A=3, B=5; pull rst_n low at cycle 4 -> out_valid=0 and outW=0 immediately (async); after release in_ready=1 and no stale result appears.
- Adder flags: opc 010, A=0x7FFF, B=0x0001, C=0 -> outW=0x8000, neg=1, ovf=1, cout=0. Then opc 000, A=0x0000 -> outW=0x0000, zer=1, cout=1.
- Shift-add: opc 011, A=0x0010, B=0xFFF0 -> B'=0xFFF8, outW=0x0008, cout=1, ovf=0. Then opc 110, A=0x12AB, B=0x34CD -> outW=0xABCD, neg=1.
- Multiply latency and sign: opc 111, A=0xFFFD (-3), B=0x0007 -> out_valid exactly 16 cycles after accept; outW=0xFFEB (-21), neg=1; busy=1 and in_ready=0 for the whole multiply.
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0, outW and flags stable for 10 cycles. Release with in_valid high (opc 101, A=0x00F0, B=0x0F00) -> next outW=0x0FF0 with no gap cycle.
- Throughput: 8 back-to-back opc 001 ops, A=0..7, out_ready=1 -> one result per cycle, outW 1..8, ordering preserved.
